layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
Parametrised, pipelined successor to the combinational colour mapper. Each pixel, it merges NUM_LAYERS palette-indexed sprite layers by fixed priority, falls back to a DrawY gradient background, and applies a frame-stepped fade. Per-layer palettes are runtime-writable instead of hard-coded. It sits between the sprite/position logic and the VGA output registers.

Parameters:
NUM_LAYERS, 12, number of sprite layers; layer 0 has highest priority
IDX_W, 4, palette index width per layer; PAL_DEPTH = 2**IDX_W
TRANSPARENT_IDX, 0, index treated as see-through on every layer
FADE_STEP, 16, fade level change per frame_start (1..256)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
pal_we  in  1  palette write strobe
pal_layer  in  $clog2(NUM_LAYERS)  palette write: target layer
pal_idx  in  IDX_W  palette write: target entry
pal_data  in  24  palette write: RGB 8:8:8
pix_valid  in  1  DrawX/DrawY and layer inputs are valid this cycle
DrawX, DrawY  in  10 each  current pixel coordinates
layer_hit  in  NUM_LAYERS  bit i: pixel falls inside layer i's sprite and layer i is alive
layer_idx  in  NUM_LAYERS*IDX_W  packed; layer i index in bits [i*IDX_W +: IDX_W]
frame_start  in  1  one-cycle pulse per frame (vsync edge)
fade_start  in  1  one-cycle fade request
VGA_R, VGA_G, VGA_B  out  8 each  registered pixel colour
out_valid  out  1  VGA_* correspond to a valid pixel
fade_busy  out  1  fade FSM not in IDLE

Behaviour:
- Reset: VGA_R/G/B=0, out_valid=0, fade_busy=0, FSM=IDLE, level=256, all pipeline valids=0. Palette contents are not reset; software loads them before use.
- Palette: NUM_LAYERS*PAL_DEPTH x 24 storage. Synchronous write on pal_we. Same-cycle read and write of the same entry returns the old data (read-first).
- Pipeline latency is exactly 3 cycles: inputs at edge n produce output at edge n+3. Fully pipelined, one pixel per cycle, no stalls. Each stage carries pix_valid and DrawY.
- S1 (priority select): the winner is the lowest i with layer_hit[i]=1 and layer_idx[i]!=TRANSPARENT_IDX. Register the winner layer and index, plus a hit flag.
- S2 (palette lookup): if hit, colour = palette[winner][idx]. Otherwise colour = background: R = 8'hFF - DrawY[8:1], G = 8'hFF, B = 8'hFF.
- S3 (fade): each channel out = (ch * level) >> 8, with a 17-bit intermediate and truncation. At level=256 the output equals the input exactly; at level=0 the output is 0. If the S3 valid is 0, VGA_*=0 and out_valid=0.
- level is sampled into S3 at the same edge as that pixel's colour. A level change therefore affects pixels from that edge onward.
- Fade FSM (level 9 bits, 0..256):
  - IDLE: level=256. fade_start -> FADE_OUT.
  - FADE_OUT: on each frame_start, level = max(level-FADE_STEP, 0). On reaching 0 -> BLACK.
  - BLACK: level=0. fade_start -> FADE_IN.
  - FADE_IN: on each frame_start, level = min(level+FADE_STEP, 256). On reaching 256 -> IDLE.
  - fade_start in FADE_OUT or FADE_IN is ignored.
  - If fade_start and frame_start arrive in the same cycle in IDLE or BLACK, only the state transition occurs; the first step happens on the next frame_start.
  - fade_busy = (state != IDLE).
- Reset asserted mid-frame or mid-fade clears the pipeline and FSM immediately; the output returns to 0 asynchronously.
- layer_hit bits for layers with all indices transparent simply never win. Bits above NUM_LAYERS do not exist.

Test Plan:
- Reset then load palette[2][5]=24'h123456. Drive layer_hit=12'b100, layer_idx[2]=5, pix_valid=1 -> three cycles later VGA=12/34/56, out_valid=1.
- Priority: palette[0][1]=FF0000, palette[3][1]=00FF00. layer_hit bits 0 and 3 set, both idx=1 -> red. Then layer_idx[0]=0 (transparent) -> green.
- No hit, DrawY=100 -> R=8'hFF-50=8'hCD, G=B=FF. Also: pix_valid=0 -> out_valid=0 and VGA=0 three cycles later.
- Fade: fade_start, then 16 frame_starts with FADE_STEP=16 -> level 256->0, state BLACK, white pixel outputs 0. At level 128, a white pixel outputs 7F/7F/7F. fade_start in FADE_OUT is ignored.
- Fade in from BLACK: fade_start plus frame_start in the same cycle -> level stays 0 that frame. 16 further frame_starts -> level 256, fade_busy falls, output is unchanged from the input colour.
- Read-first: write palette[1][3] while the same entry is being read in S2 -> the old colour is output, and the new colour appears on the next access. Also: assert Reset mid-stream -> outputs are 0 within the same cycle.

Source files
------------

// File: rtl/layer_compositor.sv
// Three-stage sprite layer compositor: priority select, palette lookup with gradient
// background, then a frame-stepped fade applied to the registered VGA colour.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS      = 12,
  parameter int unsigned IDX_W           = 4,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned FADE_STEP       = 16,
  localparam int unsigned LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned PAL_DEPTH = 2 ** IDX_W,
  localparam int unsigned AW        = LW + IDX_W
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pal_we,
  input  logic [LW-1:0]               pal_layer,
  input  logic [IDX_W-1:0]            pal_idx,
  input  logic [23:0]                 pal_data,
  input  logic                        pix_valid,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic                        frame_start,
  input  logic                        fade_start,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid,
  output logic                        fade_busy
);

  typedef enum logic [1:0] {StIdle, StFadeOut, StBlack, StFadeIn} fade_state_e;

  // The gradient only depends on DrawY[8:1]; the remaining coordinate bits are ignored.
  logic unused_coord;
  assign unused_coord = ^{DrawX, DrawY[9], DrawY[0]};

  logic [23:0] pal [NUM_LAYERS*PAL_DEPTH];

  logic             win_hit;
  logic [LW-1:0]    win_layer;
  logic [IDX_W-1:0] win_idx;

  logic             s1_valid, s1_hit;
  logic [LW-1:0]    s1_layer;
  logic [IDX_W-1:0] s1_idx;
  logic [7:0]       s1_y;
  logic             s2_valid;
  logic [23:0]      s2_col;
  logic [23:0]      bg_col;

  fade_state_e state;
  logic [8:0]  level;

  // Descending scan so the lowest eligible layer overwrites and wins.
  always_comb begin
    win_hit   = 1'b0;
    win_layer = '0;
    win_idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i] && layer_idx[i*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX)) begin
        win_hit   = 1'b1;
        win_layer = LW'(i);
        win_idx   = layer_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  assign bg_col = {8'hFF - s1_y, 8'hFF, 8'hFF};

  always_ff @(posedge Clk) begin
    if (pal_we && int'(pal_layer) < NUM_LAYERS) begin
      pal[AW'({pal_layer, pal_idx})] <= pal_data;
    end
  end

  function automatic logic [7:0] fade_ch(input logic [7:0] ch, input logic [8:0] lvl);
    logic [16:0] prod;
    prod = ch * lvl;
    return prod[15:8];
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_layer  <= '0;
      s1_idx    <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_col    <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= win_hit;
      s1_layer <= win_layer;
      s1_idx   <= win_idx;
      s1_y     <= DrawY[8:1];
      s2_valid <= s1_valid;
      // Array read sees the pre-write contents, giving read-first behaviour.
      s2_col   <= s1_hit ? pal[AW'({s1_layer, s1_idx})] : bg_col;
      out_valid <= s2_valid;
      if (s2_valid) begin
        VGA_R <= fade_ch(s2_col[23:16], level);
        VGA_G <= fade_ch(s2_col[15:8], level);
        VGA_B <= fade_ch(s2_col[7:0], level);
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= StIdle;
      level <= 9'd256;
    end else begin
      unique case (state)
        StIdle: begin
          level <= 9'd256;
          if (fade_start) state <= StFadeOut;
        end
        StFadeOut: begin
          if (frame_start) begin
            if (level <= 9'(FADE_STEP)) begin
              level <= 9'd0;
              state <= StBlack;
            end else begin
              level <= level - 9'(FADE_STEP);
            end
          end
        end
        StBlack: begin
          level <= 9'd0;
          if (fade_start) state <= StFadeIn;
        end
        StFadeIn: begin
          if (frame_start) begin
            if ({1'b0, level} + 10'(FADE_STEP) >= 10'd256) begin
              level <= 9'd256;
              state <= StIdle;
            end else begin
              level <= level + 9'(FADE_STEP);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign fade_busy = (state != StIdle);

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: directed pixels push expected colours with their
// due cycle; a negedge monitor pops and compares when each pixel reaches the output.
module tb_layer_compositor;

  localparam int NL = 12;
  localparam int IW = 4;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            pal_we = 1'b0;
  logic [3:0]      pal_layer = '0;
  logic [IW-1:0]   pal_idx = '0;
  logic [23:0]     pal_data = '0;
  logic            pix_valid = 1'b0;
  logic [9:0]      DrawX = '0;
  logic [9:0]      DrawY = '0;
  logic [NL-1:0]   layer_hit = '0;
  logic [NL*IW-1:0] layer_idx = '0;
  logic            frame_start = 1'b0;
  logic            fade_start = 1'b0;
  logic [7:0]      VGA_R, VGA_G, VGA_B;
  logic            out_valid, fade_busy;

  layer_compositor dut (
    .Clk(Clk), .Reset(Reset), .pal_we(pal_we), .pal_layer(pal_layer), .pal_idx(pal_idx),
    .pal_data(pal_data), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .layer_hit(layer_hit), .layer_idx(layer_idx), .frame_start(frame_start),
    .fade_start(fade_start), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .out_valid(out_valid), .fade_busy(fade_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic        v;
    logic [23:0] rgb;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compares every expected pixel on the exact cycle it is due.
  always @(negedge Clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      nvec++;
      if (e.due != cyc || out_valid !== e.v || {VGA_R, VGA_G, VGA_B} !== e.rgb) begin
        nerr++;
        $display("FAIL %s: got v=%0b rgb=%06h at cycle %0d, want v=%0b rgb=%06h at cycle %0d",
                 e.name, out_valid, {VGA_R, VGA_G, VGA_B}, cyc, e.v, e.rgb, e.due);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wp(input int l, input int i, input logic [23:0] d);
    pal_we = 1'b1; pal_layer = 4'(l); pal_idx = IW'(i); pal_data = d;
    step();
    pal_we = 1'b0;
  endtask

  task automatic pix(input string nm, input logic v, input logic [NL-1:0] hit,
                     input logic [NL*IW-1:0] idx, input logic [9:0] y,
                     input logic ev, input logic [23:0] ergb);
    exp_t e;
    pix_valid = v; layer_hit = hit; layer_idx = idx; DrawY = y; DrawX = 10'd7;
    e.due = cyc + 3; e.v = ev; e.rgb = ergb; e.name = nm;
    q.push_back(e);
    step();
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0; layer_hit = '0;
    repeat (n) step();
  endtask

  task automatic frame(input logic fs, input logic fst);
    frame_start = fs; fade_start = fst;
    step();
    frame_start = 1'b0; fade_start = 1'b0;
  endtask

  logic [NL*IW-1:0] iv;

  initial begin
    repeat (3) step();
    check("reset_vga", {VGA_R, VGA_G, VGA_B}, 32'h0);
    check("reset_out_valid", out_valid, 0);
    check("reset_fade_busy", fade_busy, 0);
    Reset = 1'b0;
    step();

    wp(2, 5, 24'h123456);
    iv = '0; iv[2*IW +: IW] = 4'd5;
    pix("basic_hit", 1, 12'b100, iv, 10'd0, 1, 24'h123456);

    wp(0, 1, 24'hFF0000);
    wp(3, 1, 24'h00FF00);
    iv = '0; iv[0 +: IW] = 4'd1; iv[3*IW +: IW] = 4'd1;
    pix("prio_layer0", 1, 12'b1001, iv, 10'd0, 1, 24'hFF0000);
    iv[0 +: IW] = 4'd0;
    pix("prio_transparent", 1, 12'b1001, iv, 10'd0, 1, 24'h00FF00);
    pix("bg_y100", 1, 12'b0, '0, 10'd100, 1, 24'hCDFFFF);
    pix("all_transparent_bg", 1, 12'b100000, '0, 10'd0, 1, 24'hFFFFFF);
    pix("invalid_pixel", 0, 12'b100, iv, 10'd0, 0, 24'h000000);
    pix("bg_y511", 1, 12'b0, '0, 10'd511, 1, 24'h00FFFF);
    idle(5);

    // Fade out
    frame(1'b0, 1'b1);
    check("fade_busy_out", fade_busy, 1);
    repeat (8) frame(1'b1, 1'b0);
    pix("level128_white", 1, 12'b0, '0, 10'd0, 1, 24'h7F7F7F);
    idle(4);
    frame(1'b0, 1'b1);
    pix("fade_start_ignored", 1, 12'b0, '0, 10'd0, 1, 24'h7F7F7F);
    idle(4);
    repeat (8) frame(1'b1, 1'b0);
    pix("black_white", 1, 12'b0, '0, 10'd0, 1, 24'h000000);
    idle(4);
    check("fade_busy_black", fade_busy, 1);

    // Fade in: combined pulse only changes state
    frame(1'b1, 1'b1);
    pix("fadein_first_frame", 1, 12'b0, '0, 10'd0, 1, 24'h000000);
    idle(4);
    repeat (15) frame(1'b1, 1'b0);
    pix("level240_white", 1, 12'b0, '0, 10'd0, 1, 24'hEFEFEF);
    idle(4);
    check("fade_busy_240", fade_busy, 1);
    frame(1'b1, 1'b0);
    check("fade_busy_done", fade_busy, 0);
    iv = '0; iv[2*IW +: IW] = 4'd5;
    pix("faded_in_colour", 1, 12'b100, iv, 10'd0, 1, 24'h123456);
    idle(4);

    // Read-first palette
    wp(1, 3, 24'hAABBCC);
    iv = '0; iv[1*IW +: IW] = 4'd3;
    pix("read_first_old", 1, 12'b10, iv, 10'd0, 1, 24'hAABBCC);
    pal_we = 1'b1; pal_layer = 4'd1; pal_idx = 4'd3; pal_data = 24'h445566;
    pix("read_first_new", 1, 12'b10, iv, 10'd0, 1, 24'h445566);
    pal_we = 1'b0;
    idle(5);

    // Asynchronous reset mid-stream
    pix("pre_reset_a", 1, 12'b10, iv, 10'd0, 1, 24'h445566);
    pix("pre_reset_b", 1, 12'b0, '0, 10'd100, 1, 24'hCDFFFF);
    pix("pre_reset_c", 1, 12'b0, '0, 10'd0, 1, 24'hFFFFFF);
    pix_valid = 1'b0;
    #1 Reset = 1'b1;
    #1;
    check("async_reset_vga", {VGA_R, VGA_G, VGA_B}, 32'h0);
    check("async_reset_valid", out_valid, 0);
    q.delete();
    step();
    Reset = 1'b0;
    step();

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
